// File: rtl/clock_div_pkg.sv
// Shared constants and state type for the clock divider.
// Default widths, the "divider off" setting and the IDLE/RUN state.
package clock_div_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int DIV_W_DEF = 3;
  localparam int DIV_OFF   = 0;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

endpackage

// File: rtl/clock_div_counter.sv
// Half-period counter for the clock divider.
// tc marks the last CLK cycle of a half period of lim cycles.
module clock_div_counter
  import clock_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic [CNT_W-1:0] lim,
  output logic             tc
);

  logic [CNT_W-1:0] count;

  assign tc = en && (count == lim - CNT_W'(1));

  // count CLK edges inside a half period; parked at 0 when disabled
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count <= '0;
    end else if (!en || tc) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/clock_divider.sv
// Programmable 50% duty clock divider, clk_div = CLK / (2*div).
// Optional one-cycle rise strobe `tick` under CLOCK_DIV_TICK_EN.
module clock_divider
  import clock_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [DIV_W-1:0] div,
  output logic             clk_div
`ifdef CLOCK_DIV_TICK_EN
  ,
  output logic             tick
`endif
);

  logic [DIV_W-1:0] div_q;
  state_t           state;
  logic             run;
  logic             load;
  logic             tc;

  // a zero setting means the divider is parked
  always_comb begin
    state = (div_q == DIV_W'(DIV_OFF)) ? IDLE : RUN;
  end

  // idle samples div every edge; running samples only at the 1->0 boundary
  always_comb begin
    run  = 1'b0;
    load = 1'b0;
    unique case (state)
      IDLE: begin
        load = 1'b1;
      end
      RUN: begin
        run  = 1'b1;
        load = tc && clk_div;
      end
    endcase
  end

  clock_div_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .CLK(CLK),
    .RST(RST),
    .en (run),
    .lim(CNT_W'(div_q)),
    .tc (tc)
  );

  // active divide setting
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      div_q <= '0;
    end else if (load) begin
      div_q <= div;
    end
  end

  // output toggle flop, flips at each half-period end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      clk_div <= 1'b0;
    end else if (tc) begin
      clk_div <= ~clk_div;
    end
  end

`ifdef CLOCK_DIV_TICK_EN
  // strobe aligned with each clk_div rise
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tick <= 1'b0;
    end else begin
      tick <= tc && !clk_div;
    end
  end
`endif

endmodule

// File: tb/tb_clock_divider.sv
// Testbench for clock_divider: waveform-level reference model.
// Build with CLOCK_DIV_TICK_EN to also check the tick strobe.
module tb_clock_divider;

  localparam int CNT_W = 8;
  localparam int DIV_W = 3;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic [DIV_W-1:0] div = '0;
  logic             clk_div;
`ifdef CLOCK_DIV_TICK_EN
  logic             tick;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // expected clk_div value after each upcoming CLK edge
  bit q[$];
  bit prev = 1'b0;

  clock_divider #(
    .CNT_W(CNT_W),
    .DIV_W(DIV_W)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .div    (div),
    .clk_div(clk_div)
`ifdef CLOCK_DIV_TICK_EN
    ,
    .tick   (tick)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // one CLK edge: a new output period starts whenever the previous one ran
  // out; it is d cycles low then d cycles high with d sampled at that edge
  task automatic step(string tag);
    bit e;
    int d;
    @(posedge CLK);
    if (q.size() == 0) begin
      d = int'(div);
      if (d == 0) begin
        q.push_back(1'b0);
      end else begin
        repeat (d) q.push_back(1'b0);
        repeat (d) q.push_back(1'b1);
      end
    end
    e = q.pop_front();
    #1;
    check(tag, 32'(clk_div), 32'(e));
`ifdef CLOCK_DIV_TICK_EN
    check({tag, "_tick"}, 32'(tick), 32'(e && !prev));
`endif
    prev = e;
  endtask

  task automatic run(string tag, int n);
    repeat (n) step(tag);
  endtask

  initial begin
    bit found;
    int n;

    #3;
    check("reset_async", 32'(clk_div), 32'd0);
    div = 3'd1;
    repeat (2) begin
      @(posedge CLK);
      #1;
      check("reset_hold", 32'(clk_div), 32'd0);
    end
    @(negedge CLK);
    RST = 1'b1;

    run("div1", 505);
    div = 3'd2;
    run("div2", 40);
    div = 3'd4;
    run("div4", 40);
    div = 3'd0;
    run("div0", 24);
    div = 3'd3;
    run("div3", 40);
    div = 3'd4;
    run("div4b", 10);

    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step("seek_high");
      if (prev) found = 1'b1;
    end
    check("seek_high_found", 32'(found), 32'd1);
    #2;
    RST = 1'b0;
    #1;
    check("rst_mid_high", 32'(clk_div), 32'd0);
`ifdef CLOCK_DIV_TICK_EN
    check("rst_mid_tick", 32'(tick), 32'd0);
`endif
    @(posedge CLK);
    #1;
    check("rst_mid_hold", 32'(clk_div), 32'd0);
    q.delete();
    prev = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    run("after_rst", 40);

    div = 3'd2;
    run("tick_div2", 40);

    for (int i = 0; i < 40; i++) begin
      div = DIV_W'($urandom_range(0, 7));
      n = int'($urandom_range(1, 30));
      run("rand", n);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
